// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the round-robin UART transmit arbiter.
// Used by rr_pick and uart_tx_arb.
package uart_tx_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request scanning upward
// from ptr+1 (mod NREQ). The index is meaningful only when valid=1.
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand [NREQ];
    logic [NREQ-1:0]  hit;

    // cand[k] is the requester checked k-th after ptr; ptr+k+1 < 2*NREQ so one subtraction wraps it.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, ptr} + (IDX_W+1)'(gi + 1);
            assign cand[gi]  = (sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(sum - (IDX_W+1)'(NREQ))
                                                         : sum[IDX_W-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = |hit;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte requesters.
// Optional UART_TX_ARB_LOCK_EN adds a per-requester lock input that pins ownership.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int BUSY_TMO = 16,
    localparam int IDX_W    = idx_w(NREQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0][BYTE_W-1:0]   req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NREQ-1:0]               lock,
`endif
    output logic [NREQ-1:0]               ack,
    output logic                          tx_en,
    output logic [BYTE_W-1:0]             tx_data,
    input  logic                          tx_busy,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          active,
    output logic                          tmo_err
);

    localparam int         CNT_W        = $clog2(BUSY_TMO + 1);
    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_LAUNCH    = LAUNCH;
    localparam logic [1:0] ST_WAIT_BUSY = WAIT_BUSY;
    localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

    logic [1:0]        state_reg, state_next;
    logic [IDX_W-1:0]  ptr_reg;
    logic [IDX_W-1:0]  grant_reg;
    logic [BYTE_W-1:0] data_reg;
    logic              active_reg;
    logic              tmo_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic              arb_go;
    logic              tmo_hit;

`ifdef UART_TX_ARB_LOCK_EN
    logic              owner_vld_reg;
`endif

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A locked owner overrides round-robin and blocks others even with its req low.
    always_comb begin
        win_valid = pick_valid;
        win_idx   = pick_idx;
`ifdef UART_TX_ARB_LOCK_EN
        if (owner_vld_reg && lock[grant_reg]) begin
            win_valid = req[grant_reg];
            win_idx   = grant_reg;
        end
`endif
    end

    assign arb_go  = (state_reg == ST_IDLE) && win_valid && !tx_busy;
    assign tmo_hit = (state_reg == ST_WAIT_BUSY) && !tx_busy
                     && (cnt_reg == CNT_W'(BUSY_TMO - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (arb_go) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // cnt_reg counts cycles since the launch strobe; zero during LAUNCH itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= IDX_W'(NREQ - 1);
            grant_reg  <= '0;
            data_reg   <= '0;
            active_reg <= 1'b0;
            tmo_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (arb_go) begin
                data_reg   <= req_data[win_idx];
                grant_reg  <= win_idx;
                ptr_reg    <= win_idx;
                active_reg <= 1'b1;
                cnt_reg    <= '0;
            end else begin
                if (state_reg != ST_IDLE && state_next == ST_IDLE) begin
                    active_reg <= 1'b0;
                end
                if (state_reg == ST_LAUNCH || (state_reg == ST_WAIT_BUSY && !tx_busy)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            if (tmo_hit) begin
                tmo_reg <= 1'b1;
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_vld_reg <= 1'b0;
        end else if (arb_go) begin
            owner_vld_reg <= 1'b1;
        end
    end
`endif

    always_comb begin
        ack = '0;
        if (state_reg == ST_LAUNCH) begin
            ack[grant_reg] = 1'b1;
        end
    end

    assign tx_en    = (state_reg == ST_LAUNCH);
    assign tx_data  = data_reg;
    assign grant_id = grant_reg;
    assign active   = active_reg;
    assign tmo_err  = tmo_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed plus randomized bench for uart_tx_arb with a simple uart_tx busy model.
module tb_uart_tx_arb;
    import uart_tx_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 16;
    localparam int IW   = idx_w(NREQ);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][7:0]  req_data;
    logic [NREQ-1:0]       ack;
    logic                  tx_en;
    logic [7:0]            tx_data;
    logic                  tx_busy = 1'b0;
    logic [IW-1:0]         grant_id;
    logic                  active;
    logic                  tmo_err;
`ifdef UART_TX_ARB_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif

    int n_cmp    = 0;
    int n_bad    = 0;
    int n_launch = 0;

    int busy_len  = 10;
    bit busy_en   = 1'b1;
    int busy_left = 0;
    bit arm       = 1'b0;

    uart_tx_arb #(
        .NREQ     (NREQ),
        .BUSY_TMO (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .lock     (lock),
`endif
        .ack      (ack),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .active   (active),
        .tmo_err  (tmo_err)
    );

    // uart_tx stand-in: busy rises the cycle after tx_en and stays high busy_len cycles.
    always @(posedge clk) begin
        #1;
        if (busy_left > 0) busy_left--;
        if (arm) begin
            busy_left = busy_len;
            arm = 1'b0;
        end
        if (busy_en && tx_en === 1'b1) arm = 1'b1;
        tx_busy = (busy_left > 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference arbitration rule: first pending requester after the last winner.
    function automatic int rr_model(input int last, input logic [NREQ-1:0] pend);
        for (int k = 1; k <= NREQ; k++) begin
            if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic expect_launch(input string tag, input int exp_idx, input logic [7:0] exp_data);
        bit got;
        bit stray;
        logic [NREQ-1:0] exp_ack;
        got = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (tx_en === 1'b1) got = 1'b1;
            else if (ack !== '0) stray = 1'b1;
        end
        check({tag, "_launched"}, 32'(got), 32'd1);
        check({tag, "_stray_ack"}, 32'(stray), 32'd0);
        if (got) begin
            n_launch++;
            $display("launch %0d [%s] grant=%0d data=0x%02h ack=%b", n_launch, tag, grant_id, tx_data, ack);
            exp_ack = '0;
            exp_ack[exp_idx] = 1'b1;
            check({tag, "_grant"}, 32'(grant_id), 32'(exp_idx));
            check({tag, "_data"}, 32'(tx_data), 32'(exp_data));
            check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
            check({tag, "_active"}, 32'(active), 32'd1);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (active === 1'b0 && tx_busy === 1'b0 && !arm) ok = 1'b1;
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int low_cyc;
        int launch_cyc;
        int extra_en;
        bit early;
        int m_last;
        int exp_i;
        int rearm;
        logic [NREQ-1:0] pend;
        logic [7:0] bval;

        rst = 1'b0;
        req = '0;
        req_data = '0;
`ifdef UART_TX_ARB_LOCK_EN
        lock = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_tmo", 32'(tmo_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // All four requesting: strict rotation starting at 0.
        busy_len = 4;
        for (int j = 0; j < NREQ; j++) req_data[j] = 8'(8'h10 + j);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            bval = 8'(8'h10 + (k % NREQ));
            expect_launch("rr_all", k % NREQ, bval);
        end
        req = '0;
        wait_idle("rr_all");

        // req[1] held, req[3] requests once.
        req_data[1] = 8'h21;
        req_data[3] = 8'h43;
        req = 4'b0010;
        expect_launch("hold1_a", 1, 8'h21);
        @(negedge clk);
        req[3] = 1'b1;
        expect_launch("pulse3", 3, 8'h43);
        req[3] = 1'b0;
        expect_launch("hold1_b", 1, 8'h21);
        expect_launch("hold1_c", 1, 8'h21);
        req = '0;
        wait_idle("hold1");

        // Single requester, 10-cycle frame.
        busy_len = 10;
        req_data[2] = 8'hA5;
        req = 4'b0100;
        expect_launch("single2", 2, 8'hA5);
        req = '0;
        extra_en = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (tx_en === 1'b1) extra_en++;
            if (i == 11) check("single2_active_at_fall", 32'(active), 32'd1);
            if (i == 12) check("single2_active_after", 32'(active), 32'd0);
        end
        check("single2_extra_tx_en", 32'(extra_en), 32'd0);
        check("single2_data_held", 32'(tx_data), 32'hA5);
        check("single2_grant_held", 32'(grant_id), 32'd2);

        // Busy never rises: timeout.
        busy_en = 1'b0;
        req_data[3] = 8'h3C;
        req = 4'b1000;
        expect_launch("tmo_launch", 3, 8'h3C);
        req = '0;
        first = -1;
        for (int k = 1; k <= 3 * TMO && first < 0; k++) begin
            @(negedge clk);
            if (tmo_err === 1'b1) first = k;
        end
        check("tmo_latency", 32'(first), 32'(TMO));
        check("tmo_active_low", 32'(active), 32'd0);
        busy_en = 1'b1;
        @(negedge clk);
        req_data[0] = 8'h5C;
        req = 4'b0001;
        expect_launch("after_tmo", 0, 8'h5C);
        req = '0;
        check("tmo_sticky", 32'(tmo_err), 32'd1);
        wait_idle("after_tmo");

        // Reset during WAIT_DONE while the frame keeps busy high.
        busy_len = 30;
        req_data[1] = 8'h77;
        req = 4'b0010;
        expect_launch("pre_rst", 1, 8'h77);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_tx_en", 32'(tx_en), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_grant", 32'(grant_id), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_tmo", 32'(tmo_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        low_cyc = -1;
        launch_cyc = -1;
        early = 1'b0;
        for (int i = 0; i < 100 && launch_cyc < 0; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0 && low_cyc < 0) low_cyc = i;
            if (tx_en === 1'b1) begin
                if (low_cyc < 0) early = 1'b1;
                launch_cyc = i;
                check("postrst_grant", 32'(grant_id), 32'd1);
            end
        end
        check("postrst_no_early_en", 32'(early), 32'd0);
        check("postrst_gap", 32'(launch_cyc - low_cyc), 32'd1);
        req = '0;
        wait_idle("postrst");

        // Randomized request sets against the rotation rule.
        do_reset();
        m_last = NREQ - 1;
        for (int b = 0; b < 20; b++) begin
            busy_len = int'($urandom_range(2, 6));
            pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int j = 0; j < NREQ; j++) req_data[j] = 8'($urandom);
            req = pend;
            rearm = 0;
            while (pend != '0) begin
                exp_i = rr_model(m_last, pend);
                expect_launch("rand", exp_i, req_data[exp_i]);
                m_last = exp_i;
                if (rearm < 2 && $urandom_range(0, 2) == 0) begin
                    rearm++;
                    req_data[exp_i] = 8'($urandom);
                end else begin
                    pend[exp_i] = 1'b0;
                    req[exp_i] = 1'b0;
                end
            end
            wait_idle("rand");
        end

`ifdef UART_TX_ARB_LOCK_EN
        do_reset();
        busy_len = 4;
        req_data[0] = 8'hC0;
        req_data[2] = 8'hC2;
        lock = 4'b0001;
        req = 4'b0101;
        expect_launch("lock_a", 0, 8'hC0);
        expect_launch("lock_b", 0, 8'hC0);
        expect_launch("lock_c", 0, 8'hC0);
        lock = '0;
        expect_launch("unlock", 2, 8'hC2);
        req = '0;
        wait_idle("lock");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
